// File: rtl/avg_group_scheduler_if.sv
// Control/status bundle between the averaging scheduler and its surroundings.
//   master : the scheduler (drives requests, acc_en, group/frame status, UserOutput)
//   slave  : control registers + accumulator/DRAM engines (drive start/abort, frame
//            pulses and the clear/readout acknowledges)
interface avg_group_scheduler_if #(
  parameter int unsigned GRP_W = 3,
  parameter int unsigned FRM_W = 10
);
  logic             start;
  logic             abort;
  logic             sof;
  logic             eof;
  logic             dram_clr_req;
  logic             dram_clr_ack;
  logic             acc_en;
  logic             rd_req;
  logic             rd_ack;
  logic [GRP_W-1:0] group_idx;
  logic [FRM_W-1:0] frame_cnt;
  logic             busy;
  logic             done;
  logic [1:0]       UserOutput;

  modport master (
    input  start, abort, sof, eof, dram_clr_ack, rd_ack,
    output dram_clr_req, acc_en, rd_req, group_idx, frame_cnt, busy, done, UserOutput
  );

  modport slave (
    output start, abort, sof, eof, dram_clr_ack, rd_ack,
    input  dram_clr_req, acc_en, rd_req, group_idx, frame_cnt, busy, done, UserOutput
  );
endinterface

// File: rtl/avg_group_scheduler.sv
// Sequencer for the multi-group sample-averaging run. Per group: clear the DRAM
// accumulation buffer, wait for a frame start, gate the accumulator for
// FRAMES_PER_GROUP frames, then request the averaged readout.
// Ports:
//   clk      system clock
//   aresetn  asynchronous active-low reset
//   bus      avg_group_scheduler_if.master: start/abort, sof/eof, clear and readout
//            handshakes, acc_en, group_idx, frame_cnt, busy, done, UserOutput
// All outputs are decoded from registered state, so reset forces them low at once.
module avg_group_scheduler #(
  parameter int unsigned NUM_GROUPS       = 8,
  parameter int unsigned FRAMES_PER_GROUP = 1000,
  parameter int unsigned GRP_W            = 3,
  parameter int unsigned FRM_W            = 10
) (
  input logic                   clk,
  input logic                   aresetn,
  avg_group_scheduler_if.master bus
);

  localparam logic [GRP_W-1:0] LastGroup = GRP_W'(NUM_GROUPS - 1);
  localparam logic [FRM_W-1:0] LastFrame = FRM_W'(FRAMES_PER_GROUP - 1);

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StWaitSof,
    StAcc,
    StRead,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [GRP_W-1:0] group_q, group_d;
  logic [FRM_W-1:0] frame_q, frame_d;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StIdle;
      group_q <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      group_q <= group_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    group_d = group_q;
    frame_d = frame_q;
    if (bus.abort) begin
      state_d = StIdle;
      group_d = '0;
      frame_d = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            state_d = StClr;
            group_d = '0;
            frame_d = '0;
          end
        end
        StClr: begin
          if (bus.dram_clr_ack) state_d = StWaitSof;
        end
        // Any eof seen here belongs to a partial frame and is dropped.
        StWaitSof: begin
          if (bus.sof) state_d = StAcc;
        end
        // eof wins over a coincident sof; sof is meaningless once aligned.
        StAcc: begin
          if (bus.eof) begin
            frame_d = frame_q + FRM_W'(1);
            if (frame_q == LastFrame) state_d = StRead;
          end
        end
        StRead: begin
          if (bus.rd_ack) begin
            if (group_q == LastGroup) begin
              state_d = StDone;
            end else begin
              state_d = StClr;
              group_d = group_q + GRP_W'(1);
              frame_d = '0;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    bus.dram_clr_req = 1'b0;
    bus.acc_en       = 1'b0;
    bus.rd_req       = 1'b0;
    bus.busy         = 1'b0;
    bus.done         = 1'b0;
    bus.UserOutput   = 2'b00;
    unique case (state_q)
      StIdle: ;
      StClr: begin
        bus.dram_clr_req = 1'b1;
        bus.busy         = 1'b1;
        bus.UserOutput   = 2'b10;
      end
      StWaitSof: begin
        bus.busy       = 1'b1;
        bus.UserOutput = 2'b10;
      end
      StAcc: begin
        bus.acc_en     = 1'b1;
        bus.busy       = 1'b1;
        bus.UserOutput = 2'b01;
      end
      StRead: begin
        bus.rd_req     = 1'b1;
        bus.busy       = 1'b1;
        bus.UserOutput = 2'b10;
      end
      StDone: begin
        bus.done       = 1'b1;
        bus.UserOutput = 2'b11;
      end
      default: ;
    endcase
  end

  assign bus.group_idx = group_q;
  assign bus.frame_cnt = frame_q;

endmodule

// File: tb/tb_avg_group_scheduler.sv
// Randomized bench for avg_group_scheduler with a small run (2 groups x 4 frames).
// The stimulus process advances a reference model of the run and queues the
// expected outputs for the next cycle; a monitor pops and compares at each negedge.
module tb_avg_group_scheduler;
  localparam int unsigned NGRP  = 2;
  localparam int unsigned NFRM  = 4;
  localparam int unsigned GRP_W = 3;
  localparam int unsigned FRM_W = 10;

  logic clk;
  logic aresetn;

  avg_group_scheduler_if #(.GRP_W(GRP_W), .FRM_W(FRM_W)) bus ();

  avg_group_scheduler #(
    .NUM_GROUPS      (NGRP),
    .FRAMES_PER_GROUP(NFRM),
    .GRP_W           (GRP_W),
    .FRM_W           (FRM_W)
  ) dut (
    .clk    (clk),
    .aresetn(aresetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {clr_req, acc_en, rd_req, busy, done, UserOutput[1:0], group_idx[2:0], frame_cnt[9:0]}
  typedef logic [19:0] obs_t;

  typedef enum int {MIdle, MClr, MWait, MAcc, MRead, MDone} phase_e;

  phase_e m_phase;
  int     m_grp;
  int     m_frm;
  obs_t   exp_q[$];
  bit     mon_en;
  int     checks;
  int     errors;

  function automatic obs_t dut_obs();
    return {bus.dram_clr_req, bus.acc_en, bus.rd_req, bus.busy, bus.done, bus.UserOutput,
            bus.group_idx, bus.frame_cnt};
  endfunction

  // Expected outputs straight from the per-phase output table of the run.
  function automatic obs_t model_obs();
    logic clr, acc, rd, bsy, dn;
    logic [1:0] uo;
    clr = (m_phase == MClr);
    acc = (m_phase == MAcc);
    rd  = (m_phase == MRead);
    dn  = (m_phase == MDone);
    bsy = clr || acc || rd || (m_phase == MWait);
    uo  = acc ? 2'b01 : dn ? 2'b11 : bsy ? 2'b10 : 2'b00;
    return {clr, acc, rd, bsy, dn, uo, GRP_W'(m_grp), FRM_W'(m_frm)};
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s t=%0t actual=%05h required=%05h", name, $time, act, expv);
    end
  endtask

  task automatic model_reset();
    m_phase = MIdle;
    m_grp   = 0;
    m_frm   = 0;
  endtask

  task automatic model_step(input bit rst_n, input bit st, input bit ab, input bit sf,
                            input bit ef, input bit ca, input bit ra);
    if (!rst_n || ab) begin
      model_reset();
      return;
    end
    case (m_phase)
      MIdle, MDone: if (st) begin m_phase = MClr; m_grp = 0; m_frm = 0; end
      MClr:  if (ca) m_phase = MWait;
      MWait: if (sf) m_phase = MAcc;
      MAcc: begin
        if (ef) begin
          m_frm++;
          if (m_frm == NFRM) m_phase = MRead;
        end
      end
      MRead: begin
        if (ra) begin
          if (m_grp == NGRP - 1) m_phase = MDone;
          else begin m_grp++; m_frm = 0; m_phase = MClr; end
        end
      end
      default: model_reset();
    endcase
  endtask

  // One clock of stimulus: drive after the monitor sampled, then queue the outcome.
  task automatic cycle(input bit rst_n, input bit st, input bit ab, input bit sf,
                       input bit ef, input bit ca, input bit ra);
    @(negedge clk);
    #1;
    aresetn          = rst_n;
    bus.start        = st;
    bus.abort        = ab;
    bus.sof          = sf;
    bus.eof          = ef;
    bus.dram_clr_ack = ca;
    bus.rd_ack       = ra;
    model_step(rst_n, st, ab, sf, ef, ca, ra);
    exp_q.push_back(model_obs());
  endtask

  task automatic rand_cycle(input int start_pct, input int abort_permille);
    cycle(1'b1,
          $urandom_range(0, 99) < start_pct,
          $urandom_range(0, 999) < abort_permille,
          $urandom_range(0, 99) < 20,
          $urandom_range(0, 99) < 30,
          $urandom_range(0, 99) < 35,
          $urandom_range(0, 99) < 35);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty t=%0t actual=%05h required=<none>", $time, dut_obs());
      end else begin
        check("cycle_outputs", dut_obs(), exp_q.pop_front());
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    model_reset();
    aresetn          = 1'b0;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.sof          = 1'b0;
    bus.eof          = 1'b0;
    bus.dram_clr_ack = 1'b0;
    bus.rd_ack       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", dut_obs(), model_obs());

    // Release reset; acks/frames arrive with no request pending and must be ignored.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    repeat (20) rand_cycle(0, 0);

    // Directed: start, clear, eofs in WAIT_SOF, then sof; sof+eof together in ACC.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Random runs without abort so DONE and restarts from DONE are reached.
    repeat (1500) rand_cycle(4, 0);
    // Random runs with occasional aborts.
    repeat (1500) rand_cycle(5, 15);

    // Asynchronous reset mid-ACC: outputs must clear before any clock edge.
    for (int i = 0; i < 400 && !(m_phase == MAcc && m_frm > 0); i++) rand_cycle(10, 0);
    @(negedge clk);
    #2;
    aresetn = 1'b0;
    #1;
    check("async_reset_outputs", dut_obs(), {20{1'b0}});
    model_reset();
    exp_q.push_back(model_obs());
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (300) rand_cycle(5, 5);

    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
